// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory subsystem.
// Defines the physical address and data widths, the requester identity
// enum, and the read tag that travels down the read pipeline beside each
// BRAM port-B access.
package cpu_mem_pkg;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 8;
    localparam int STARVE_W = 4;    // wide enough for a starvation limit of up to 15

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_EXEC  = 1'b1
    } port_id_t;

    // live = 0 marks an empty slot or a fetch read discarded by a flush.
    typedef struct packed {
        logic              live;
        port_id_t          port;
        logic [ADDR_W-1:0] addr;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{live: 1'b0, port: PORT_FETCH, addr: '0};

    // Drop a fetch entry when kill is asserted; exec entries always survive.
    function automatic rd_tag_t kill_fetch(input rd_tag_t tag, input logic kill);
        rd_tag_t res;
        res = tag;
        if (kill && (tag.port == PORT_FETCH)) begin
            res.live = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Two-stage tag shift register that follows each BRAM port-B read.
// Stage 0 is loaded on the edge that issues the read, stage 1 on the edge
// the BRAM updates dob, and out_tag is consumed on the edge that registers
// the response.
// Ports:
//   clk, rst  clock / asynchronous active-high reset
//   kill      discard every fetch entry currently in the pipe, including
//             the one about to leave through out_tag
//   in_tag    tag of the read issued this cycle (live = 0 when none)
//   out_tag   tag matching the current dob value
module ram_read_pipe
    import cpu_mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    kill,
    input  rd_tag_t in_tag,
    output rd_tag_t out_tag
);

    localparam int DEPTH = 2;

    rd_tag_t stage_reg  [DEPTH];
    rd_tag_t stage_next [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = in_tag;
            end else begin : g_body
                assign stage_next[gi] = kill_fetch(stage_reg[gi-1], kill);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= RD_TAG_IDLE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= stage_next[i];
            end
        end
    end

    // The last stage is killed combinationally so a flush also stops the
    // response that would otherwise be registered on the flush edge.
    assign out_tag = kill_fetch(stage_reg[DEPTH-1], kill);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a simple dual-port BRAM between the instruction fetcher
// (read-only) and the execute stage (read or write). Writes use port A,
// reads use port B, so only reads are arbitrated. Reads have a fixed
// 2-cycle latency and responses come back in acceptance order.
// Ports:
//   clk, rst                       clock / asynchronous active-high reset
//   fetch_req_*                    fetch read request handshake
//   fetch_flush                    discard in-flight fetch reads
//   fetch_rsp_*                    fetch read response (1-cycle pulse)
//   exec_req_*                     execute read/write request handshake
//   exec_rsp_*                     execute read response (1-cycle pulse)
//   ena/wea/addra/dia              BRAM port A (write)
//   enb/addrb/dob                  BRAM port B (read, 1-cycle latency)
module ram_port_arbiter
#(
    parameter int ADDR_W       = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W       = cpu_mem_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_valid,
    input  logic [ADDR_W-1:0] fetch_req_addr,
    output logic              fetch_req_ready,
    input  logic              fetch_flush,
    output logic              fetch_rsp_valid,
    output logic [ADDR_W-1:0] fetch_rsp_addr,
    output logic [DATA_W-1:0] fetch_rsp_data,
    input  logic              exec_req_valid,
    input  logic              exec_req_we,
    input  logic [ADDR_W-1:0] exec_req_addr,
    input  logic [DATA_W-1:0] exec_req_wdata,
    output logic              exec_req_ready,
    output logic              exec_rsp_valid,
    output logic [DATA_W-1:0] exec_rsp_data,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dia,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dob
);

    import cpu_mem_pkg::*;

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic                exec_wr, exec_rd, hazard, fetch_eligible, fetch_forced;
    logic                fetch_acc, exec_rd_acc, rd_acc;
    logic [ADDR_W-1:0]   rd_addr;
    rd_tag_t             issue_tag, done_tag;

    logic              ena_reg, wea_reg, enb_reg;
    logic [ADDR_W-1:0] addra_reg, addrb_reg, fetch_rsp_addr_reg;
    logic [DATA_W-1:0] dia_reg, fetch_rsp_data_reg, exec_rsp_data_reg;
    logic              fetch_rsp_valid_reg, exec_rsp_valid_reg;

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
    assign exec_wr = exec_req_valid && exec_req_we;
    assign exec_rd = exec_req_valid && !exec_req_we;

    // Port B reads the pre-write contents when a write to the same address
    // lands on the same edge, so the fetch waits one cycle for the new value.
    assign hazard         = exec_wr && fetch_req_valid && (fetch_req_addr == exec_req_addr);
    assign fetch_eligible = !fetch_flush && !hazard;
    assign fetch_forced   = (starve_cnt_reg == STARVE_MAX);

    assign fetch_req_ready = fetch_eligible && (!exec_rd || fetch_forced);
    assign exec_req_ready  = exec_req_we || !(fetch_req_valid && fetch_eligible && fetch_forced);

    assign fetch_acc   = fetch_req_valid && fetch_req_ready;
    assign exec_rd_acc = exec_rd && exec_req_ready;
    assign rd_acc      = fetch_acc || exec_rd_acc;
    assign rd_addr     = fetch_acc ? fetch_req_addr : exec_req_addr;

    // Counts only genuine losses to an exec read; flushed or stalled
    // cycles hold the count.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!fetch_req_valid || fetch_acc) begin
            starve_cnt_next = '0;
        end else if (fetch_eligible && exec_rd_acc && !fetch_forced) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        issue_tag      = RD_TAG_IDLE;
        issue_tag.live = rd_acc;
        issue_tag.port = fetch_acc ? PORT_FETCH : PORT_EXEC;
        issue_tag.addr = rd_addr;
    end

    ram_read_pipe u_read_pipe (
        .clk     (clk),
        .rst     (rst),
        .kill    (fetch_flush),
        .in_tag  (issue_tag),
        .out_tag (done_tag)
    );

    // ---------------------------------------------------------------
    // Registered BRAM controls and responses
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg      <= '0;
            ena_reg             <= 1'b0;
            wea_reg             <= 1'b0;
            addra_reg           <= '0;
            dia_reg             <= '0;
            enb_reg             <= 1'b0;
            addrb_reg           <= '0;
            fetch_rsp_valid_reg <= 1'b0;
            fetch_rsp_addr_reg  <= '0;
            fetch_rsp_data_reg  <= '0;
            exec_rsp_valid_reg  <= 1'b0;
            exec_rsp_data_reg   <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;

            ena_reg <= exec_wr;
            wea_reg <= exec_wr;
            if (exec_wr) begin
                addra_reg <= exec_req_addr;
                dia_reg   <= exec_req_wdata;
            end

            enb_reg <= rd_acc;
            if (rd_acc) begin
                addrb_reg <= rd_addr;
            end

            fetch_rsp_valid_reg <= done_tag.live && (done_tag.port == PORT_FETCH);
            exec_rsp_valid_reg  <= done_tag.live && (done_tag.port == PORT_EXEC);
            if (done_tag.live && (done_tag.port == PORT_FETCH)) begin
                fetch_rsp_addr_reg <= done_tag.addr;
                fetch_rsp_data_reg <= dob;
            end
            if (done_tag.live && (done_tag.port == PORT_EXEC)) begin
                exec_rsp_data_reg <= dob;
            end
        end
    end

    assign ena             = ena_reg;
    assign wea             = wea_reg;
    assign addra           = addra_reg;
    assign dia             = dia_reg;
    assign enb             = enb_reg;
    assign addrb           = addrb_reg;
    assign fetch_rsp_valid = fetch_rsp_valid_reg;
    assign fetch_rsp_addr  = fetch_rsp_addr_reg;
    assign fetch_rsp_data  = fetch_rsp_data_reg;
    assign exec_rsp_valid  = exec_rsp_valid_reg;
    assign exec_rsp_data   = exec_rsp_data_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural dual-port BRAM, a
// transaction-level reference model (golden memory + expected-response
// queue + starvation rule), directed scenarios and a random phase.
module tb_ram_port_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req_valid, fetch_req_ready, fetch_flush;
    logic [AW-1:0] fetch_req_addr, fetch_rsp_addr;
    logic          fetch_rsp_valid;
    logic [DW-1:0] fetch_rsp_data;
    logic          exec_req_valid, exec_req_we, exec_req_ready, exec_rsp_valid;
    logic [AW-1:0] exec_req_addr;
    logic [DW-1:0] exec_req_wdata, exec_rsp_data;
    logic          ena, wea, enb;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dia, dob;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr),
        .fetch_req_ready(fetch_req_ready), .fetch_flush(fetch_flush),
        .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_addr(fetch_rsp_addr),
        .fetch_rsp_data(fetch_rsp_data),
        .exec_req_valid(exec_req_valid), .exec_req_we(exec_req_we),
        .exec_req_addr(exec_req_addr), .exec_req_wdata(exec_req_wdata),
        .exec_req_ready(exec_req_ready), .exec_rsp_valid(exec_rsp_valid),
        .exec_rsp_data(exec_rsp_data),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .enb(enb), .addrb(addrb), .dob(dob)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: read-first on port B, plus a preload path.
    logic [DW-1:0] bram [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) bram[pl_addr] <= pl_data;
        else if (ena && wea) bram[addra] <= dia;
        if (enb) dob <= bram[addrb];
    end

    // Reference model state
    typedef struct {
        bit            is_fetch;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    exp_t          exp_q [$];
    int            starve = 0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input bit fv, input int fa, input bit fl,
                         input bit ev, input bit we, input int ea, input int wd);
        fetch_req_valid = fv;
        fetch_req_addr  = fa[AW-1:0];
        fetch_flush     = fl;
        exec_req_valid  = ev;
        exec_req_we     = we;
        exec_req_addr   = ea[AW-1:0];
        exec_req_wdata  = wd[DW-1:0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock cycle: check readies before the edge, advance the model at
    // the edge, check BRAM controls and responses just after it.
    task automatic step();
        bit            fv, fl, ev, we, hz, erd, elig, f_win, e_win, fe, ee;
        logic [AW-1:0] fa, ea, ra;
        logic [DW-1:0] wd;
        exp_t          e;
        #1;
        fv = fetch_req_valid; fa = fetch_req_addr; fl = fetch_flush;
        ev = exec_req_valid;  we = exec_req_we;    ea = exec_req_addr; wd = exec_req_wdata;
        hz    = ev && we && fv && (fa == ea);
        erd   = ev && !we;
        elig  = fv && !fl && !hz;
        f_win = elig && (!erd || starve == LIMIT);
        e_win = erd && !f_win;
        if (fv) check("fetch_req_ready", fetch_req_ready, f_win);
        if (ev) check("exec_req_ready", exec_req_ready, we || e_win);
        @(posedge clk);
        cyc++;
        if (fl) begin
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].is_fetch) exp_q.delete(i);
        end
        ra = f_win ? fa : ea;
        if (f_win || e_win) begin
            e.is_fetch = f_win;
            e.addr     = ra;
            e.data     = ref_mem[ra];
            e.due      = cyc + 2;
            exp_q.push_back(e);
        end
        if (ev && we) ref_mem[ea] = wd;
        if (!fv || f_win) starve = 0;
        else if (elig && e_win && starve < LIMIT) starve++;
        #1;
        check("ena", ena, ev && we);
        check("wea", wea, ev && we);
        if (ev && we) begin
            check("addra", addra, ea);
            check("dia", dia, wd);
        end
        check("enb", enb, f_win || e_win);
        if (f_win || e_win) check("addrb", addrb, ra);
        fe = 0;
        ee = 0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e  = exp_q.pop_front();
            fe = e.is_fetch;
            ee = !e.is_fetch;
        end
        check("fetch_rsp_valid", fetch_rsp_valid, fe);
        check("exec_rsp_valid", exec_rsp_valid, ee);
        if (fe) begin
            check("fetch_rsp_addr", fetch_rsp_addr, e.addr);
            check("fetch_rsp_data", fetch_rsp_data, e.data);
            $display("cycle %0d: fetch rsp addr=%0d data=%02h", cyc, fetch_rsp_addr, fetch_rsp_data);
        end
        if (ee) begin
            check("exec_rsp_data", exec_rsp_data, e.data);
            $display("cycle %0d: exec rsp addr=%0d data=%02h", cyc, e.addr, exec_rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fetch_rsp_valid"}, fetch_rsp_valid, 0);
        check({tag, "_fetch_rsp_addr"}, fetch_rsp_addr, 0);
        check({tag, "_fetch_rsp_data"}, fetch_rsp_data, 0);
        check({tag, "_exec_rsp_valid"}, exec_rsp_valid, 0);
        check({tag, "_exec_rsp_data"}, exec_rsp_data, 0);
        check({tag, "_ena"}, ena, 0);
        check({tag, "_wea"}, wea, 0);
        check({tag, "_addra"}, addra, 0);
        check({tag, "_dia"}, dia, 0);
        check({tag, "_enb"}, enb, 0);
        check({tag, "_addrb"}, addrb, 0);
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic apply_reset(input int n, input bit rand_in);
        rst = 1'b1;
        if (rand_in)
            drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom);
        exp_q.delete();
        starve = 0;
        #1;
        check_zero("reset");
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_zero("reset");
        end
        @(negedge clk);
        idle();
        rst = 1'b0;
        $display("cycle %0d: reset released", cyc);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #2;
        rst = 1'b1;

        // Preload RAM (DUT held in reset), 92..95 = 0x10..0x13.
        for (int i = 0; i < (1 << AW); i++)
            ref_mem[i] = (i >= 92 && i <= 95) ? DW'(16 + i - 92) : DW'($urandom);
        for (int i = 0; i < (1 << AW); i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = AW'(i);
            pl_data = ref_mem[i];
        end
        @(negedge clk);
        pl_en = 1'b0;

        // 1. Reset with random inputs, then idle.
        apply_reset(3, 1);
        step();
        step();

        // 2. Fetch burst 92..95.
        for (int a = 92; a <= 95; a++) begin
            drive(1, a, 0, 0, 0, 0, 0);
            step();
        end
        idle();
        repeat (3) step();

        // 3. Contention: exec wins 4, fetch wins the 5th.
        for (int i = 0; i < 10; i++) begin
            drive(1, 100, 0, 1, 0, 200, 0);
            #1;
            check("contention_fetch_ready", fetch_req_ready, (i % 5) == 4);
            check("contention_exec_ready", exec_req_ready, (i % 5) != 4);
            step();
        end
        idle();
        repeat (3) step();

        // 4. Same-address write/read hazard.
        drive(1, 120, 0, 1, 1, 120, 'hAB);
        step();
        drive(1, 120, 0, 0, 0, 0, 0);
        step();
        idle();
        repeat (3) step();

        // 5. Flush with exec read of 300 in the flush cycle.
        drive(1, 92, 0, 0, 0, 0, 0);
        step();
        drive(1, 93, 0, 0, 0, 0, 0);
        step();
        drive(1, 94, 1, 1, 0, 300, 0);
        step();
        idle();
        repeat (3) step();

        // 6. Reset while an exec read is in flight.
        drive(0, 0, 0, 1, 0, 310, 0);
        step();
        idle();
        step();
        apply_reset(1, 0);
        repeat (3) step();
        drive(0, 0, 0, 1, 0, 311, 0);
        step();
        idle();
        repeat (3) step();

        // Random phase on a small address window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 64 + $urandom_range(0, 7),
                  $urandom_range(0, 99) < 8,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
                  64 + $urandom_range(0, 7), $urandom);
            step();
        end
        idle();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
